jk_ff_b: RTL and testbench
==========================

// Module: jk_ff_b
// PURPOSE
//   Positive-edge JK flip-flop, scalable to a bank of WIDTH independent bits.
//   Provides true and complementary outputs.
//   Leaf storage primitive for counters and small sequential control logic.
//   Clocked by CLK and cleared by RST.
// PARAMETERS
//   WIDTH    1     number of independent JK bits; bit i uses J[i], K[i], Q[i] and QN[i]
//   RST_VAL  1'b0  per-bit value loaded into Q on reset, replicated to WIDTH bits
// PORTS
//   CLK  in   1      clock; all state changes occur on the rising edge only
//   RST  in   1      reset; asynchronous, active-high; forces Q=RST_VAL
//   J    in   WIDTH  set/toggle input, one bit per flip-flop
//   K    in   WIDTH  reset/toggle input, one bit per flip-flop
//   Q    out  WIDTH  registered state
//   QN   out  WIDTH  complement of Q (~Q), always
// BEHAVIOUR
//   - Interface: one clock (CLK); reset RST is asynchronous and active-high.
//   - Reset:
//     - RST rising forces Q=RST_VAL and QN=~RST_VAL immediately, without waiting for a clock edge.
//     - While RST=1, the state holds at reset values regardless of CLK, J and K.
//     - This includes J/K at X/Z: no X may propagate to Q during reset.
//   - Release:
//     - On RST deassertion, nothing changes until the next CLK rising edge.
//     - The first edge with RST=0 evaluates J/K normally.
//   - Per bit, on each CLK rising edge with RST=0:
//     - J=0,K=0: hold, Q unchanged
//     - J=0,K=1: reset, Q<=0
//     - J=1,K=0: set, Q<=1
//     - J=1,K=1: toggle, Q<=~Q
//   - Timing:
//     - Latency is one edge: Q reflects J/K sampled at edge n immediately after edge n.
//     - No combinational path from J/K to Q or QN.
//     - QN is derived from the same register as Q, never a second register, so Q==~QN at all times.
//   - Toggle: sustained J=K=1 divides CLK by 2 on Q (period 2*Tclk).
//   - Bits are fully independent: no carry or interaction between indices.
//   - RST asserted mid-toggle overrides any pending edge. Asynchronous reset wins over a simultaneous CLK edge.
// CONFIGURATION
//   JK_FF_B_CE_EN:
//     - Defined: adds input port CE (1 bit, after RST). A rising edge with CE=0 holds all bits regardless of J/K.
//     - CE does not gate reset; RST still clears asynchronously.
//     - CE=1 gives the normal JK behaviour above.
//   Undefined: no CE port; every rising edge evaluates J/K.
// TESTING
//   Benches: CLK period 10 ns, WIDTH=1, RST_VAL=0.
//   1. Reset: RST=1 for 80 ns with J/K=X -> Q=0, QN=1 throughout. No X on outputs after the first RST assertion.
//   2. Set: RST=0, J=1,K=0 for 8 edges -> Q=1,QN=0 after the first edge, then stable.
//   3. Hold: J=0,K=0 for 8 edges from Q=1 -> Q stays 1. Then J=0,K=1 -> Q=0 after one edge.
//   4. Toggle: J=1,K=1 for 8 edges from Q=0 -> Q alternates 1,0,1,0,...
//      Ends at Q=0 after the 8th edge; Q==~QN at every sample.
//   5. Async reset: assert RST 3 ns after an edge while toggling with Q=1 -> Q=0 within the same cycle, before the next edge.
//      Hold RST for 2 edges -> Q stays 0.
//   6. With JK_FF_B_CE_EN: CE=0, J=1,K=0 for 4 edges -> Q holds 0. CE=1 -> Q=1 after one edge.
//      With WIDTH=4: J=4'b1010, K=4'b0101 -> Q=4'b1010.

Source files
------------

// File: rtl/jk_ff_b_if.sv
// JK flip-flop bank bus: J/K stimulus in, true/complement state out.
// Master drives J/K; slave (the flop bank) drives Q/QN.
interface jk_ff_b_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;

    modport master (
        output J,
        output K,
        input  Q,
        input  QN
    );

    modport slave (
        input  J,
        input  K,
        output Q,
        output QN
    );
endinterface

// File: rtl/jk_ff_b.sv
// Bank of WIDTH independent positive-edge JK flops, async active-high reset.
// Optional clock enable port CE when JK_FF_B_CE_EN is defined.
module jk_ff_b #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
`ifdef JK_FF_B_CE_EN
    input  logic       CE,
`endif
    jk_ff_b_if.slave   bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // J sets a low bit, ~K keeps a high bit: covers hold/set/reset/toggle.
    always_comb begin
        q_d = (bus.J & ~q_q) | (~bus.K & q_q);
`ifdef JK_FF_B_CE_EN
        if (!CE) q_d = q_q;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) q_q <= {WIDTH{RST_VAL}};
        else     q_q <= q_d;
    end

    // Both outputs come from the single state register.
    assign bus.Q  = q_q;
    assign bus.QN = ~q_q;
endmodule

// File: tb/tb_jk_ff_b.sv
// Scoreboard bench for jk_ff_b: 1-bit and 4-bit banks on a shared clock.
// Build with +define+JK_FF_B_CE_EN to exercise the clock enable.
module tb_jk_ff_b;
    logic CLK;
    logic RST;
    logic ce;

    jk_ff_b_if #(.WIDTH(1)) bus1 ();
    jk_ff_b_if #(.WIDTH(4)) bus4 ();

    jk_ff_b #(.WIDTH(1), .RST_VAL(1'b0)) u1 (
        .CLK (CLK),
        .RST (RST),
`ifdef JK_FF_B_CE_EN
        .CE  (ce),
`endif
        .bus (bus1)
    );

    jk_ff_b #(.WIDTH(4), .RST_VAL(1'b0)) u4 (
        .CLK (CLK),
        .RST (RST),
`ifdef JK_FF_B_CE_EN
        .CE  (ce),
`endif
        .bus (bus4)
    );

    typedef struct packed {
        logic [3:0] q1;
        logic [3:0] q4;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m1;
    logic [3:0] m4;
    int         n_vec;
    int         n_err;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] jk(input logic [3:0] q,
                                      input logic [3:0] j,
                                      input logic [3:0] k,
                                      input logic       en);
        logic [3:0] r;
        r = q;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                case ({j[i], k[i]})
                    2'b00:   r[i] = q[i];
                    2'b01:   r[i] = 1'b0;
                    2'b10:   r[i] = 1'b1;
                    default: r[i] = ~q[i];
                endcase
            end
        end
        return r;
    endfunction

    task automatic look(input string tag);
        chk({tag, ".q1"},  {3'b000, bus1.Q}, m1);
        chk({tag, ".qn1"}, {3'b000, ~bus1.QN}, m1);
        chk({tag, ".q4"},  bus4.Q, m4);
        chk({tag, ".qn4"}, ~bus4.QN, m4);
    endtask

    // Drive at the current (low) phase, check #1 after the edge,
    // return at the next falling edge.
    task automatic step(input string tag,
                        input logic j1, input logic k1,
                        input logic [3:0] j4, input logic [3:0] k4,
                        input logic en);
        exp_t e;
        bus1.J = j1;
        bus1.K = k1;
        bus4.J = j4;
        bus4.K = k4;
`ifdef JK_FF_B_CE_EN
        ce = en;
`endif
        m1 = jk(m1, {3'b000, j1}, {3'b000, k1}, en);
        m4 = jk(m4, j4, k4, en);
        e.q1 = m1;
        e.q4 = m4;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb"}, 4'd0, 4'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".q1"},  {3'b000, bus1.Q}, e.q1);
            chk({tag, ".qn1"}, {3'b000, ~bus1.QN}, e.q1);
            chk({tag, ".q4"},  bus4.Q, e.q4);
            chk({tag, ".qn4"}, ~bus4.QN, e.q4);
        end
        @(negedge CLK);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ce    = 1'b1;
        m1    = 4'd0;
        m4    = 4'd0;
        RST   = 1'b1;
        bus1.J = 1'bx;
        bus1.K = 1'bx;
        bus4.J = 4'bxxxx;
        bus4.K = 4'bxxxx;
        #1;
        look("rst0");
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            look("rst_hold");
            @(negedge CLK);
        end

        // Release at 80 ns; state must not move before the next edge.
        RST = 1'b0;
        #1;
        look("release");

        for (int i = 0; i < 8; i++)
            step("set", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++)
            step("hold", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        step("clr", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++)
            step("tog", 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("tog_end", {3'b000, bus1.Q}, 4'd0);

        // Toggle to 1, then reset 3 ns after that edge.
        bus1.J = 1'b1;
        bus1.K = 1'b1;
        m1 = jk(m1, 4'b0001, 4'b0001, 1'b1);
        @(posedge CLK);
        #1;
        look("pre_arst");
        #2;
        RST = 1'b1;
        m1 = 4'd0;
        m4 = 4'd0;
        #1;
        look("arst");
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            look("arst_hold");
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        look("arst_rel");
        step("tog_rel", 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
        step("clr2", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);

`ifdef JK_FF_B_CE_EN
        for (int i = 0; i < 4; i++)
            step("ce0", 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
        step("ce1", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
        step("clr3", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
`endif

        step("w4_a", 1'b0, 1'b0, 4'b1010, 4'b0101, 1'b1);
        step("w4_t", 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
        step("w4_m", 1'b0, 1'b0, 4'b0011, 4'b1001, 1'b1);
        step("w4_h", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++)
            step("w4_r", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);

        chk("sb_empty", 4'(sb.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
